// File: rtl/fetch_unit.sv
// Front-end fetch stage: sequential PC generation, two-wide requests to a
// one-cycle-latency imem, and an in-order fetch queue feeding decode.
module fetch_unit #(
  parameter int unsigned FETCH_W     = 2,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            imem_req_valid,
  output logic [31:0]                     imem_req_addr,
  input  logic [FETCH_W-1:0][31:0]        imem_rdata,
  input  logic                            redirect_valid,
  input  logic [31:0]                     redirect_pc,
  input  logic                            decode_ready,
  output logic [FETCH_W-1:0]              instr_valid,
  output logic [FETCH_W-1:0][31:0]        instr,
  output logic [FETCH_W-1:0][31:0]        pc,
  output logic [$clog2(QUEUE_DEPTH):0]    fq_count
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_vld_p1;
  logic [31:0]   r_req_addr_p1;
  logic [31:0]   r_instr_q [QUEUE_DEPTH];
  logic [31:0]   r_pc_q    [QUEUE_DEPTH];

  logic [CW:0]   w_need;
  logic          w_push;
  logic [CW-1:0] w_push_n;
  logic [CW-1:0] w_pop_n;
  logic          w_unused;

  function automatic logic [CW-1:0] lane_count(input logic [FETCH_W-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < FETCH_W; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign w_unused = ^redirect_pc[1:0];

  // Stage p0: issue. Space check uses registered occupancy plus the pair
  // already in flight, so a response can always be accepted unconditionally.
  always_comb begin
    w_need         = {1'b0, r_count} + (r_vld_p1 ? (CW+1)'(4) : (CW+1)'(2));
    imem_req_valid = !reset && !redirect_valid && (w_need <= (CW+1)'(QUEUE_DEPTH));
    imem_req_addr  = r_fetch_pc;
  end

  // Stage p1: response arrives; queue push and decode presentation.
  always_comb begin
    w_push   = r_vld_p1 && !redirect_valid && !reset;
    w_push_n = w_push ? CW'(2) : '0;
  end

  always_comb begin
    instr_valid = '0;
    instr       = '0;
    pc          = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      instr_valid[i] = (r_count >= CW'(i + 1)) && !redirect_valid;
      instr[i]       = r_instr_q[r_head + PW'(i)];
      pc[i]          = r_pc_q[r_head + PW'(i)];
    end
  end

  always_comb begin
    w_pop_n = decode_ready ? lane_count(instr_valid) : '0;
  end

  assign fq_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_vld_p1   <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      if (imem_req_valid) r_fetch_pc <= r_fetch_pc + 32'd8;
      if (w_push) r_tail <= r_tail + PW'(2);
      r_head   <= r_head + PW'(w_pop_n);
      r_count  <= r_count + w_push_n - w_pop_n;
      r_vld_p1 <= imem_req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req_valid) r_req_addr_p1 <= r_fetch_pc;
    if (w_push) begin
      r_instr_q[r_tail]         <= imem_rdata[0];
      r_pc_q[r_tail]            <= r_req_addr_p1;
      r_instr_q[r_tail + PW'(1)] <= imem_rdata[1];
      r_pc_q[r_tail + PW'(1)]    <= r_req_addr_p1 + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  localparam int unsigned FW  = 2;
  localparam int unsigned QD  = 8;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   imem_req_valid;
  logic [31:0]            imem_req_addr;
  logic [FW-1:0][31:0]    imem_rdata;
  logic                   redirect_valid = 1'b0;
  logic [31:0]            redirect_pc = '0;
  logic                   decode_ready = 1'b1;
  logic [FW-1:0]          instr_valid;
  logic [FW-1:0][31:0]    instr;
  logic [FW-1:0][31:0]    pc;
  logic [$clog2(QD):0]    fq_count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.FETCH_W(FW), .QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .decode_ready(decode_ready),
    .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  // Instruction memory where the word at address a is a itself.
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_a = '0;
  always @(posedge clk) begin
    rsp_v <= imem_req_valid;
    rsp_a <= imem_req_addr;
  end
  assign imem_rdata = rsp_v ? {rsp_a + 32'd4, rsp_a} : {32'hDEAD_BEEF, 32'hBAAD_F00D};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of PCs in program order.
  logic [31:0] m_q[$];
  logic [31:0] m_fetch = RPC;
  bit          m_inf = 1'b0;
  logic [31:0] m_req = '0;
  bit          chk_en = 1'b0;
  bit          seq_en = 1'b0;
  bit          watch40 = 1'b0;
  logic [31:0] seq_pc = '0;

  always @(negedge clk) begin : cmp
    int sz;
    int npop;
    bit issue;
    bit ev;
    sz    = m_q.size();
    issue = !reset && !redirect_valid && (sz + 2 * int'(m_inf) + 2 <= int'(QD));
    if (chk_en) begin
      check("req_valid", 64'(imem_req_valid), 64'(issue));
      check("req_addr", 64'(imem_req_addr), 64'(m_fetch));
      check("fq_count", 64'(fq_count), 64'(sz));
      for (int i = 0; i < 2; i++) begin
        ev = (sz > i) && !redirect_valid;
        check($sformatf("lane%0d_valid", i), 64'(instr_valid[i]), 64'(ev));
        if (ev) begin
          check($sformatf("lane%0d_pc", i), 64'(pc[i]), 64'(m_q[i]));
          check($sformatf("lane%0d_instr", i), 64'(instr[i]), 64'(m_q[i]));
        end
      end
      if (seq_en) begin
        for (int i = 0; i < 2; i++) begin
          if (instr_valid[i] && decode_ready) begin
            check("seq_pc", 64'(pc[i]), 64'(seq_pc));
            seq_pc = seq_pc + 32'd4;
          end
        end
      end
      if (watch40) begin
        for (int i = 0; i < 2; i++) begin
          if (instr_valid[i])
            check("no_stale_0x40", 64'(pc[i] == 32'h40 || pc[i] == 32'h44), 64'(0));
        end
      end
    end
    if (reset) begin
      m_q.delete();
      m_fetch = RPC;
      m_inf   = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
      m_inf   = 1'b0;
    end else begin
      npop = decode_ready ? ((sz >= 2) ? 2 : sz) : 0;
      repeat (npop) void'(m_q.pop_front());
      if (m_inf) begin
        m_q.push_back(m_req);
        m_q.push_back(m_req + 32'd4);
      end
      if (issue) begin
        m_req   = m_fetch;
        m_fetch = m_fetch + 32'd8;
      end
      m_inf = issue;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 with reset released.
  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Reset state
    next_cycle();
    chk_en = 1'b1;
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'(0));
    check("rst_instr_valid", 64'(instr_valid), 64'(0));
    check("rst_fq_count", 64'(fq_count), 64'(0));
    check("rst_req_addr", 64'(imem_req_addr), 64'(RPC));

    // Startup with decode always ready
    decode_ready = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    check("c0_req_valid", 64'(imem_req_valid), 64'(1));
    check("c0_req_addr", 64'(imem_req_addr), 64'(32'h0));
    next_cycle(); #1;
    check("c1_req_addr", 64'(imem_req_addr), 64'(32'h8));
    check("c1_instr_valid", 64'(instr_valid), 64'(2'b00));
    next_cycle(); #1;
    check("c2_instr_valid", 64'(instr_valid), 64'(2'b11));
    check("c2_pc", pc, {32'd4, 32'd0});
    check("c2_instr", instr, {32'd4, 32'd0});
    check("c2_fq_count", 64'(fq_count), 64'(2));
    next_cycle(); #1;
    check("c3_pc", pc, {32'hC, 32'h8});
    repeat (8) next_cycle();

    // Backpressure from cycle 0
    decode_ready = 1'b0;
    do_reset();
    repeat (4) next_cycle();
    #1;
    check("bp_c4_req_valid", 64'(imem_req_valid), 64'(0));
    check("bp_c4_fq_count", 64'(fq_count), 64'(6));
    next_cycle(); #1;
    check("bp_c5_fq_count", 64'(fq_count), 64'(8));
    check("bp_c5_pc", pc, {32'd4, 32'd0});
    next_cycle();
    next_cycle();
    next_cycle();
    decode_ready = 1'b1;
    #1;
    check("bp_c8_pc", pc, {32'd4, 32'd0});
    check("bp_c8_req_valid", 64'(imem_req_valid), 64'(0));
    repeat (4) next_cycle();
    #1;
    check("bp_c12_pc", pc, {32'h24, 32'h20});
    repeat (6) next_cycle();

    // Redirect with 6 entries queued
    decode_ready = 1'b0;
    do_reset();
    repeat (4) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    check("rd_T_fq_count", 64'(fq_count), 64'(6));
    check("rd_T_instr_valid", 64'(instr_valid), 64'(2'b00));
    check("rd_T_req_valid", 64'(imem_req_valid), 64'(0));
    next_cycle();
    redirect_valid = 1'b0;
    decode_ready   = 1'b1;
    #1;
    check("rd_T1_fq_count", 64'(fq_count), 64'(0));
    check("rd_T1_instr_valid", 64'(instr_valid), 64'(2'b00));
    check("rd_T1_req_addr", 64'(imem_req_addr), 64'(32'h100));
    check("rd_T1_req_valid", 64'(imem_req_valid), 64'(1));
    next_cycle();
    next_cycle(); #1;
    check("rd_T3_instr_valid", 64'(instr_valid), 64'(2'b11));
    check("rd_T3_pc", pc, {32'h104, 32'h100});
    repeat (4) next_cycle();

    // Redirect in the same cycle the 0x40 response returns
    decode_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (imem_req_valid && imem_req_addr == 32'h40) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    check("found_req_0x40", 64'(found), 64'(1));
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    watch40        = 1'b1;
    next_cycle();
    redirect_valid = 1'b0;
    next_cycle();
    next_cycle(); #1;
    check("rdr_T3_instr_valid", 64'(instr_valid), 64'(2'b11));
    check("rdr_T3_pc", pc, {32'h204, 32'h200});
    repeat (6) next_cycle();
    watch40 = 1'b0;

    // Pseudo-random decode stalls across many pointer wraps
    decode_ready = 1'b1;
    do_reset();
    seq_pc = 32'h0;
    seq_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      next_cycle();
      decode_ready = 1'($urandom_range(0, 1));
    end
    next_cycle();
    seq_en = 1'b0;
    check("seq_progress", 64'(seq_pc >= 32'd200), 64'(1));

    // Reset mid-stream with a request in flight
    decode_ready = 1'b0;
    do_reset();
    repeat (3) next_cycle();
    #1;
    check("mr_pre_fq_count", 64'(fq_count), 64'(4));
    reset = 1'b1;
    #1;
    check("mr_req_valid_in_reset", 64'(imem_req_valid), 64'(0));
    next_cycle();
    reset = 1'b0;
    decode_ready = 1'b1;
    #1;
    check("mr_c0_fq_count", 64'(fq_count), 64'(0));
    check("mr_c0_instr_valid", 64'(instr_valid), 64'(2'b00));
    check("mr_c0_req_addr", 64'(imem_req_addr), 64'(RPC));
    check("mr_c0_req_valid", 64'(imem_req_valid), 64'(1));
    next_cycle();
    next_cycle(); #1;
    check("mr_c2_instr_valid", 64'(instr_valid), 64'(2'b11));
    check("mr_c2_pc", pc, {32'd4, 32'd0});
    repeat (3) next_cycle();

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
